// File: rtl/menu_ram_seq_if.sv
// menu_ram_seq_if: SDRAM controller and host word-port signals for the menu RAM sequencer.
interface menu_ram_seq_if;
    logic        sdram_ready;
    logic [15:0] sdram_dout;
    logic [26:0] sdram_addr;
    logic [15:0] sdram_din;
    logic        sdram_we;
    logic        sdram_rd;
    logic [15:0] cfg;
    logic        clear_done;
    logic        host_req;
    logic        host_we;
    logic [26:0] host_addr;
    logic [15:0] host_din;
    logic [15:0] host_dout;
    logic        host_ack;
    modport slave (
        input  sdram_ready, sdram_dout, host_req, host_we, host_addr, host_din,
        output sdram_addr, sdram_din, sdram_we, sdram_rd, cfg, clear_done, host_dout, host_ack
    );
    modport master (
        output sdram_ready, sdram_dout, host_req, host_we, host_addr, host_din,
        input  sdram_addr, sdram_din, sdram_we, sdram_rd, cfg, clear_done, host_dout, host_ack
    );
endinterface

// File: rtl/menu_ram_seq.sv
// menu_ram_seq: probes SDRAM size with aliasing markers, zero-clears the detected range,
// and interleaves host word accesses with the clear at command boundaries.
module menu_ram_seq #(
    parameter int CLR_GAP = 32
) (
    input logic           clk_sys,
    input logic           RESET,
    menu_ram_seq_if.slave bus
);
    typedef enum logic [3:0] {IDLE_INIT, W0, W1, W2, W3, R0, R1, R2, SEL, CLEAR, RUN} state_t;
    typedef enum logic [1:0] {P_IDLE, P_STB, P_GAP, P_WAIT} phase_t;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [26:0] addr_q, addr_d, clr_ptr_q, clr_ptr_d, last_addr, probe_addr;
    logic [15:0] din_q, din_d, cfg_q, cfg_d, hdout_q, hdout_d, probe_data;
    logic [7:0]  gap_q, gap_d;
    logic        we_q, we_d, rd_q, rd_d, host_q, host_d, hwe_q, hwe_d, clear_done_q, clear_done_d;
    logic        boundary, done, probe, probe_we, serve, host_go, clr_go, probe_go, issue;
    logic        clr_last, clr_finish, ack;

    assign boundary   = phase_q == P_IDLE && bus.sdram_ready;
    assign done       = phase_q == P_WAIT && bus.sdram_ready;
    assign probe      = state_q inside {W0, W1, W2, W3, R0, R1, R2};
    assign probe_we   = state_q inside {W0, W1, W2, W3};
    assign serve      = state_q == CLEAR || state_q == RUN;
    assign host_go    = boundary && serve && bus.host_req;
    assign clr_go     = boundary && state_q == CLEAR && !bus.host_req && gap_q == 8'd0;
    assign probe_go   = boundary && probe;
    assign issue      = host_go || clr_go || probe_go;
    assign probe_addr = state_q == W0 || state_q == R0 ? 27'h4000000 :
                        state_q == W1 || state_q == R1 ? 27'h2000000 :
                        state_q == W3 ? 27'h1000000 : 27'h0;
    assign probe_data = state_q == W0 ? 16'd3128 : state_q == W1 ? 16'd2064 :
                        state_q == W2 ? 16'd1032 : state_q == W3 ? 16'd12345 : 16'd0;
    assign last_addr  = cfg_q[2] ? 27'h3FFFFFE : cfg_q[1] ? 27'h1FFFFFE : 27'h0FFFFFE;
    assign clr_last   = clr_ptr_q == last_addr;
    assign clr_finish = state_q == CLEAR && done && !host_q && clr_last;
    // An in-flight host command never acks across a reset.
    assign ack        = done && host_q && !RESET;

    assign bus.sdram_addr = addr_q;
    assign bus.sdram_din  = din_q;
    assign bus.sdram_we   = we_q;
    assign bus.sdram_rd   = rd_q;
    assign bus.cfg        = cfg_q;
    assign bus.clear_done = clear_done_q;
    assign bus.host_ack   = ack;
    assign bus.host_dout  = hdout_d;

    always_ff @(posedge clk_sys) state_q <= RESET ? IDLE_INIT : state_d;

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE_INIT && bus.sdram_ready) state_d = W0;
        else if (probe && done) state_d = state_t'(state_q + 4'd1);
        else if (state_q == SEL) state_d = cfg_q[2:0] == 3'd0 ? RUN : CLEAR;
        else if (clr_finish) state_d = RUN;
    end

    always_comb begin
        phase_d = issue ? P_STB : phase_q == P_STB ? P_GAP : phase_q == P_GAP ? P_WAIT :
                  done ? P_IDLE : phase_q;
        we_d    = host_go ? bus.host_we : clr_go || (probe_go && probe_we);
        rd_d    = host_go ? !bus.host_we : probe_go && !probe_we;
        addr_d  = host_go ? bus.host_addr & ~27'd1 : clr_go ? clr_ptr_q : probe_go ? probe_addr : addr_q;
        din_d   = host_go ? bus.host_din : clr_go ? 16'd0 : probe_go ? probe_data : din_q;
        host_d  = issue ? host_go : host_q;
        hwe_d   = host_go ? bus.host_we : hwe_q;
        // The spacing counter runs regardless of host traffic.
        gap_d   = clr_go ? 8'(CLR_GAP - 1) : gap_q != 8'd0 ? gap_q - 8'd1 : gap_q;
        clr_ptr_d = state_q == CLEAR && done && !host_q && !clr_last ? clr_ptr_q + 27'd2 : clr_ptr_q;
        cfg_d     = cfg_q;
        cfg_d[2]  = state_q == R0 && done ? bus.sdram_dout == 16'd3128 : cfg_q[2];
        cfg_d[1]  = state_q == R1 && done ? bus.sdram_dout == 16'd2064 : cfg_q[1];
        cfg_d[0]  = state_q == R2 && done ? bus.sdram_dout == 16'd1032 : cfg_q[0];
        cfg_d[15] = state_q == R2 && done ? 1'b1 : cfg_q[15];
        clear_done_d = clear_done_q || (state_q == SEL && cfg_q[2:0] == 3'd0) || clr_finish;
        hdout_d = ack && !hwe_q ? bus.sdram_dout : hdout_q;
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            phase_q      <= P_IDLE;
            addr_q       <= '0;
            din_q        <= '0;
            we_q         <= 1'b0;
            rd_q         <= 1'b0;
            host_q       <= 1'b0;
            hwe_q        <= 1'b0;
            gap_q        <= '0;
            clr_ptr_q    <= '0;
            cfg_q        <= '0;
            clear_done_q <= 1'b0;
            hdout_q      <= '0;
        end else begin
            phase_q      <= phase_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            we_q         <= we_d;
            rd_q         <= rd_d;
            host_q       <= host_d;
            hwe_q        <= hwe_d;
            gap_q        <= gap_d;
            clr_ptr_q    <= clr_ptr_d;
            cfg_q        <= cfg_d;
            clear_done_q <= clear_done_d;
            hdout_q      <= hdout_d;
        end
    end
endmodule
